// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, FSM state codes and SCK edge selection.
package spi_pkg;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   // Picks the sample (is_sample=1) or shift (is_sample=0) SCK edge for a {CKP,CPH} mode.
   function automatic logic edge_sel(input logic [1:0] mode, input logic is_sample,
                                     input logic rise, input logic fall);
      logic sel;
      case (mode)
         MODE0, MODE3: sel = is_sample ? rise : fall;
         MODE1, MODE2: sel = is_sample ? fall : rise;
         default:      sel = 1'b0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// SYNC_N-deep synchronizer for an asynchronous level with rise/fall pulses on the synced copy.
module spi_sync_edge #(
   parameter int unsigned SYNC_N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_N-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_N-2:0], din};
         prev_q <= sync_q[SYNC_N-1];
      end
   end

   assign rise_c = sync_q[SYNC_N-1] & ~prev_q;
   assign fall_c = ~sync_q[SYNC_N-1] & prev_q;

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI slave receiver/transmitter in the clk domain, all four CKP/CPH modes.
// Optional sticky overrun flag when SPI_RX_OVERRUN_EN is defined.
module spi_slave_receiver
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SYNC_N = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              SCK,
   input  logic              CS,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              busy
`ifdef SPI_RX_OVERRUN_EN
   ,
   output logic              overrun
`endif
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   spi_state_e        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              busy_d, miso_d, rx_valid_d;
   logic [DATA_W-1:0] rx_data_d;
   logic [SYNC_N-1:0] mosi_sync_q;
   logic              mosi_s;
   logic              sck_rise, sck_fall, cs_rise, cs_fall;
   logic              sample_e, shift_e;
`ifdef SPI_RX_OVERRUN_EN
   logic              overrun_d;
`endif

   spi_sync_edge #(.SYNC_N(SYNC_N)) u_sck_sync (
      .clk(clk), .rst(rst), .din(SCK), .rise_c(sck_rise), .fall_c(sck_fall)
   );

   spi_sync_edge #(.SYNC_N(SYNC_N)) u_cs_sync (
      .clk(clk), .rst(rst), .din(CS), .rise_c(cs_rise), .fall_c(cs_fall)
   );

   assign mosi_s = mosi_sync_q[SYNC_N-1];

   // Next-state and next-output logic; hold_q makes the next shift edge only present the MSB.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      hold_d     = hold_q;
      done_d     = 1'b0;
      busy_d     = busy;
      rx_data_d  = rx_data;
      rx_valid_d = rx_valid & ~rx_ack;
`ifdef SPI_RX_OVERRUN_EN
      overrun_d  = overrun;
`endif
      sample_e   = edge_sel(mode_q, 1'b1, sck_rise, sck_fall);
      shift_e    = edge_sel(mode_q, 1'b0, sck_rise, sck_fall);

      case (state_q)
         ST_IDLE: begin
            mode_d    = {CKP, CPH};
            bit_cnt_d = '0;
            if (cs_fall) begin
               tx_shift_d = tx_data;
               hold_d     = CPH;
               busy_d     = 1'b1;
               state_d    = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (done_q) begin
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               bit_cnt_d  = '0;
               tx_shift_d = tx_data;
               hold_d     = 1'b1;
`ifdef SPI_RX_OVERRUN_EN
               if (rx_valid && !rx_ack) overrun_d = 1'b1;
`endif
            end else begin
               if (sample_e) begin
                  rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                  bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                  done_d     = (bit_cnt_d == CNT_W'(DATA_W));
               end
               if (shift_e) begin
                  if (hold_q) hold_d = 1'b0;
                  else        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
               end
            end
            if (cs_rise) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               busy_d    = 1'b0;
               done_d    = 1'b0;
            end
         end
      endcase

      miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         bit_cnt_q   <= '0;
         hold_q      <= 1'b0;
         done_q      <= 1'b0;
         busy        <= 1'b0;
         MISO        <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         mosi_sync_q <= '0;
`ifdef SPI_RX_OVERRUN_EN
         overrun     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         bit_cnt_q   <= bit_cnt_d;
         hold_q      <= hold_d;
         done_q      <= done_d;
         busy        <= busy_d;
         MISO        <= miso_d;
         rx_data     <= rx_data_d;
         rx_valid    <= rx_valid_d;
         mosi_sync_q <= {mosi_sync_q[SYNC_N-2:0], MOSI};
`ifdef SPI_RX_OVERRUN_EN
         overrun     <= overrun_d;
`endif
      end
   end

endmodule
